// File: rtl/stump_mem_pkg.sv
// Shared constants for the Stump memory responder: I/O page offsets and TX_STAT layout.
package stump_mem_pkg;

    localparam logic [7:0] IO_PAGE_DEFAULT = 8'hFF;

    localparam logic [7:0] OFF_OUT_PORT = 8'h00;
    localparam logic [7:0] OFF_CYCLES   = 8'h01;
    localparam logic [7:0] OFF_TX_DATA  = 8'h02;
    localparam logic [7:0] OFF_TX_STAT  = 8'h03;
    localparam logic [7:0] OFF_HALT     = 8'hFF;

    localparam int unsigned STAT_EMPTY = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_OVF   = 2;
    localparam int unsigned STAT_CNT   = 3;

endpackage

// File: rtl/stump_tx_fifo.sv
// Character TX FIFO: power-of-two depth, simultaneous push/pop allowed even when full.
module stump_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [7:0]                    data_i,
    input  logic                          pop_i,
    output logic [7:0]                    head_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    buf_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) buf_q[wptr_q] <= data_i;
    end

    assign head_o  = empty_o ? 8'h00 : buf_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/stump_mem_responder.sv
// Memory-side responder for the Stump bus: zero-wait word RAM plus an I/O page with
// output port, cycle counter, TX FIFO and sticky halt.
module stump_mem_responder
    import stump_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  IO_PAGE    = IO_PAGE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] address_i,
    input  logic [15:0] data_out_i,
    input  logic        mem_wen_i,
    input  logic        mem_ren_i,
    output logic [15:0] data_in_o,
    output logic [15:0] out_port_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        halted_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0] ram_q [DEPTH];
    logic [15:0] out_port_q, out_port_d;
    logic [15:0] cycles_q, cycles_d;
    logic        overflow_q, overflow_d;
    logic        halted_q, halted_d;

    logic          in_ram, in_io, wr_en, ram_we, io_we;
    logic [7:0]    io_off;
    logic          tx_push, tx_pop, fifo_empty, fifo_full;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [15:0]   tx_stat;

    // RAM takes priority so a large DEPTH can never alias into the I/O page.
    assign in_ram = ({16'b0, address_i} < DEPTH);
    assign in_io  = !in_ram && (address_i[15:8] == IO_PAGE);
    assign io_off = address_i[7:0];
    assign wr_en  = mem_wen_i && !halted_q;
    assign ram_we = wr_en && in_ram;
    assign io_we  = wr_en && in_io;

    assign tx_push = io_we && (io_off == OFF_TX_DATA);
    assign tx_pop  = tx_valid_o && tx_ready_i;

    stump_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .data_i  (data_out_i[7:0]),
        .pop_i   (tx_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (ram_we) ram_q[address_i[AW-1:0]] <= data_out_i;
    end

    always_comb begin
        out_port_d = out_port_q;
        cycles_d   = cycles_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;
        if (io_we && (io_off == OFF_OUT_PORT)) out_port_d = data_out_i;
        if (io_we && (io_off == OFF_CYCLES))   cycles_d = 16'h0000;
        else if (!halted_q)                    cycles_d = cycles_q + 16'd1;
        if (tx_push && fifo_full && !tx_pop)        overflow_d = 1'b1;
        else if (io_we && (io_off == OFF_TX_STAT))  overflow_d = 1'b0;
        if (io_we && (io_off == OFF_HALT))     halted_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_port_q <= 16'h0000;
            cycles_q   <= 16'h0000;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            out_port_q <= out_port_d;
            cycles_q   <= cycles_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        tx_stat                  = 16'h0000;
        tx_stat[STAT_EMPTY]      = fifo_empty;
        tx_stat[STAT_FULL]       = fifo_full;
        tx_stat[STAT_OVF]        = overflow_q;
        tx_stat[STAT_CNT +: 3]   = 3'(fifo_count);
    end

    always_comb begin
        data_in_o = 16'h0000;
        if (mem_ren_i) begin
            if (in_ram) begin
                data_in_o = ram_q[address_i[AW-1:0]];
            end else if (in_io) begin
                case (io_off)
                    OFF_OUT_PORT: data_in_o = out_port_q;
                    OFF_CYCLES:   data_in_o = cycles_q;
                    OFF_TX_STAT:  data_in_o = tx_stat;
                    OFF_HALT:     data_in_o = {15'b0, halted_q};
                    default:      data_in_o = 16'h0000;
                endcase
            end
        end
    end

    assign out_port_o = out_port_q;
    assign tx_data_o  = fifo_head;
    assign tx_valid_o = !fifo_empty;
    assign halted_o   = halted_q;

endmodule
